// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory.
// Covers access sizes, the request FSM states and the alignment rule.
package mem_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'd0,
      MEM_H = 2'd1,
      MEM_W = 2'd2,
      MEM_D = 2'd3
   } mem_size_e;

   typedef enum logic {
      MS_IDLE = 1'b0,
      MS_WAIT = 1'b1
   } mem_state_e;

   // Offset must be a multiple of the access size; doubles do not exist on RV32.
   function automatic logic mem_misaligned(mem_size_e size, logic [2:0] offset, int xlen);
      logic r;
      r = 1'b0;
      case (size)
         MEM_B: r = 1'b0;
         MEM_H: r = offset[0];
         MEM_W: r = |offset[1:0];
         MEM_D: r = (xlen == 32) || (|offset);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus between the MEM stage and the data memory.
// The master is the core pipeline, the slave is data_memory.
interface data_memory_if #(
   parameter int XLEN = 64
);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [63:0]     req_addr;
   logic [1:0]      req_size;
   logic            req_unsigned;
   logic [XLEN-1:0] req_wdata;
   logic            rsp_valid;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load alignment: pick the addressed bytes out of a memory word,
// move them to bit 0 and sign- or zero-extend to XLEN.
module mem_load_align
   import mem_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] i_word,
   input  logic [2:0]      i_off,
   input  mem_size_e       i_size,
   input  logic            i_uns,
   output logic [XLEN-1:0] o_data
);

   logic [XLEN-1:0] w_sh;
   logic [XLEN-1:0] w_ext_w;

   assign w_sh = i_word >> {i_off, 3'b000};

   // A word load is already full width on RV32, so no extension bits there.
   generate
      if (XLEN > 32) begin : g_ext_w
         assign w_ext_w = {{(XLEN-32){~i_uns & w_sh[31]}}, w_sh[31:0]};
      end else begin : g_no_ext_w
         assign w_ext_w = w_sh;
      end
   endgenerate

   always_comb begin
      o_data = w_sh;
      case (i_size)
         MEM_B:   o_data = {{(XLEN-8){~i_uns & w_sh[7]}}, w_sh[7:0]};
         MEM_H:   o_data = {{(XLEN-16){~i_uns & w_sh[15]}}, w_sh[15:0]};
         MEM_W:   o_data = w_ext_w;
         default: o_data = w_sh;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed data memory for the MEM stage with sub-word stores, extended
// loads, misalignment errors and a fixed LATENCY valid/ready handshake.
module data_memory
   import mem_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int DEPTH   = 32768,
   parameter int LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst,
   data_memory_if.slave bus
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);

   logic [XLEN-1:0] r_mem [DEPTH];

   mem_state_e      r_state, w_next;
   logic [1:0]      r_cnt;
   logic [XLEN-1:0] r_rword;
   logic [2:0]      r_off;
   mem_size_e       r_size;
   logic            r_uns, r_we, r_err;
   logic [XLEN-1:0] r_hold_rdata;
   logic            r_hold_err;

   logic            w_ready, w_rsp_valid, w_accept, w_err;
   logic [IDX_W-1:0] w_idx;
   logic [2:0]      w_off;
   mem_size_e       w_size;
   logic [3:0]      w_lo, w_hi;
   logic [NB-1:0]   w_be;
   logic [XLEN-1:0] w_wdata_sh;
   logic [XLEN-1:0] w_aligned, w_result;
   logic            w_unused_addr;

   assign w_size        = mem_size_e'(bus.req_size);
   assign w_idx         = bus.req_addr[OFF_W +: IDX_W];
   assign w_off         = 3'(bus.req_addr[OFF_W-1:0]);
   assign w_unused_addr = ^bus.req_addr[63:OFF_W+IDX_W];
   assign w_err         = mem_misaligned(w_size, w_off, XLEN);
   assign w_accept      = bus.req_valid && w_ready;

   // Byte lane b is written when it falls in [offset, offset + 2^size).
   assign w_lo       = {1'b0, w_off};
   assign w_hi       = w_lo + (4'd1 << bus.req_size);
   assign w_wdata_sh = bus.req_wdata << {w_off, 3'b000};

   genvar b;
   generate
      for (b = 0; b < NB; b++) begin : g_be
         assign w_be[b] = (4'(b) >= w_lo) && (4'(b) < w_hi);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_rword <= r_mem[w_idx];
         r_off   <= w_off;
         r_size  <= w_size;
         r_uns   <= bus.req_unsigned;
         r_we    <= bus.req_we;
         r_err   <= w_err;
         if (bus.req_we && !w_err) begin
            for (int i = 0; i < NB; i++) begin
               if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wdata_sh[i*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= MS_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept)
            r_cnt <= 2'(LATENCY - 1);
         else if (r_state == MS_WAIT && r_cnt != 2'd0)
            r_cnt <= r_cnt - 2'd1;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_ready     = 1'b0;
      w_rsp_valid = 1'b0;
      case (r_state)
         MS_IDLE: begin
            w_ready = !rst;
            if (bus.req_valid && !rst) w_next = MS_WAIT;
         end
         MS_WAIT: begin
            if (r_cnt == 2'd0) begin
               w_rsp_valid = !rst;
               w_next      = MS_IDLE;
            end
         end
         default: w_next = MS_IDLE;
      endcase
   end

   mem_load_align #(.XLEN(XLEN)) u_align (
      .i_word (r_rword),
      .i_off  (r_off),
      .i_size (r_size),
      .i_uns  (r_uns),
      .o_data (w_aligned)
   );

   assign w_result = (r_err || r_we) ? '0 : w_aligned;

   // Response fields are live during the pulse and held afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_rdata <= '0;
         r_hold_err   <= 1'b0;
      end else if (w_rsp_valid) begin
         r_hold_rdata <= w_result;
         r_hold_err   <= r_err;
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_rdata = w_rsp_valid ? w_result : r_hold_rdata;
   assign bus.rsp_err   = w_rsp_valid ? r_err    : r_hold_err;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: two instances (LATENCY 1 and 3, DEPTH 16) checked every
// cycle against a byte-array model, plus directed literal checks.
module tb_data_memory;

   typedef struct {
      int          due;
      logic [63:0] rd;
      logic        er;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  t_valid = '0;
   logic        t_we = 1'b0;
   logic [63:0] t_addr = '0;
   logic [1:0]  t_size = '0;
   logic        t_uns = 1'b0;
   logic [63:0] t_wdata = '0;

   logic        w_ready [2];
   logic        w_rsp   [2];
   logic [63:0] w_rdata [2];
   logic        w_err   [2];

   data_memory_if #(.XLEN(64)) ifa ();
   data_memory_if #(.XLEN(64)) ifb ();

   assign ifa.req_valid = t_valid[0];
   assign ifb.req_valid = t_valid[1];
   assign ifa.req_we = t_we;       assign ifb.req_we = t_we;
   assign ifa.req_addr = t_addr;   assign ifb.req_addr = t_addr;
   assign ifa.req_size = t_size;   assign ifb.req_size = t_size;
   assign ifa.req_unsigned = t_uns; assign ifb.req_unsigned = t_uns;
   assign ifa.req_wdata = t_wdata; assign ifb.req_wdata = t_wdata;
   assign w_ready[0] = ifa.req_ready; assign w_ready[1] = ifb.req_ready;
   assign w_rsp[0]   = ifa.rsp_valid; assign w_rsp[1]   = ifb.rsp_valid;
   assign w_rdata[0] = ifa.rsp_rdata; assign w_rdata[1] = ifb.rsp_rdata;
   assign w_err[0]   = ifa.rsp_err;   assign w_err[1]   = ifb.rsp_err;

   data_memory #(.XLEN(64), .DEPTH(16), .LATENCY(1)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
   data_memory #(.XLEN(64), .DEPTH(16), .LATENCY(3)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

   int          lat [2] = '{1, 3};
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [7:0]  mm [2][128];
   exp_t        exp_q [2][$];
   int          acc_cyc [2][$];
   logic [63:0] last_rd [2] = '{64'd0, 64'd0};
   logic        last_er [2] = '{1'b0, 1'b0};

   task automatic chk(string name, int d, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, d, cyc, act, exp);
      end
   endtask

   // Reference: memory as 128 bytes; alignment, lanes and extension by arithmetic.
   function automatic void model(int d, logic we, logic [63:0] a, logic [1:0] sz, logic uns,
                                 logic [63:0] wd, output logic [63:0] rd, output logic er);
      int n;
      int base;
      logic [63:0] v;
      n    = 1 << sz;
      base = int'(a % 128);
      er   = (a % n) != 0;
      rd   = '0;
      if (er) return;
      if (we) begin
         for (int i = 0; i < n; i++) mm[d][(base + i) % 128] = wd[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < n; i++) v = v | (64'(mm[d][(base + i) % 128]) << (8*i));
         if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
         rd = v;
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            chk("ready_in_reset", d, 64'(w_ready[d]), 64'd0);
            chk("rsp_valid_in_reset", d, 64'(w_rsp[d]), 64'd0);
            exp_q[d].delete();
            last_rd[d] = '0;
            last_er[d] = 1'b0;
         end else begin
            logic        e_ready;
            logic        e_v;
            logic [63:0] m_rd;
            logic        m_er;
            e_ready = exp_q[d].size() == 0;
            e_v     = !e_ready && exp_q[d][0].due == cyc;
            chk("req_ready", d, 64'(w_ready[d]), 64'(e_ready));
            chk("rsp_valid", d, 64'(w_rsp[d]), 64'(e_v));
            if (e_v) begin
               chk("rsp_rdata", d, w_rdata[d], exp_q[d][0].rd);
               chk("rsp_err", d, 64'(w_err[d]), 64'(exp_q[d][0].er));
               last_rd[d] = exp_q[d][0].rd;
               last_er[d] = exp_q[d][0].er;
               void'(exp_q[d].pop_front());
            end else begin
               chk("rdata_hold", d, w_rdata[d], last_rd[d]);
               chk("err_hold", d, 64'(w_err[d]), 64'(last_er[d]));
            end
            if (t_valid[d] && e_ready) begin
               exp_t e;
               model(d, t_we, t_addr, t_size, t_uns, t_wdata, m_rd, m_er);
               e.due = cyc + lat[d];
               e.rd  = m_rd;
               e.er  = m_er;
               exp_q[d].push_back(e);
               acc_cyc[d].push_back(cyc);
            end
         end
      end
   end

   task automatic do_req(int d, logic we, logic [63:0] addr, logic [1:0] sz, logic uns,
                         logic [63:0] wd, output logic [63:0] rd, output logic er);
      int n;
      @(posedge clk); #1;
      t_we = we; t_addr = addr; t_size = sz; t_uns = uns; t_wdata = wd;
      t_valid[d] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!w_ready[d] && n < 20);
      if (!w_ready[d]) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout dut%0d: ready stayed 0, expected 1", d);
      end
      @(posedge clk); #1;
      t_valid[d] = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!w_rsp[d] && n < 20);
      if (!w_rsp[d]) begin
         n_vec++; n_err++;
         $display("FAIL rsp_timeout dut%0d: rsp_valid stayed 0, expected 1", d);
      end
      rd = w_rdata[d];
      er = w_err[d];
   endtask

   initial begin
      logic [63:0] rd;
      logic        er;
      logic [63:0] a;
      logic [1:0]  sz;
      int          s;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_ready", d, 64'(w_ready[d]), 64'd1);
         chk("reset_rdata", d, w_rdata[d], 64'd0);
         chk("reset_err", d, 64'(w_err[d]), 64'd0);
      end

      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 16; w++)
            do_req(d, 1'b1, 64'(w * 8), 2'd3, 1'b0, {$urandom, $urandom}, rd, er);

      // Directed sequence on the LATENCY=1 instance
      do_req(0, 1'b1, 64'h40, 2'd3, 1'b0, 64'h1122334455667788, rd, er);
      chk("store_d_err", 0, 64'(er), 64'd0);
      do_req(0, 1'b0, 64'h40, 2'd3, 1'b0, 64'h0, rd, er);
      chk("load_d", 0, rd, 64'h1122334455667788);
      chk("load_d_err", 0, 64'(er), 64'd0);
      do_req(0, 1'b1, 64'h43, 2'd0, 1'b0, 64'h00000000000000AB, rd, er);
      do_req(0, 1'b0, 64'h40, 2'd3, 1'b0, 64'h0, rd, er);
      chk("byte_lane", 0, rd, 64'h11223344AB667788);
      do_req(0, 1'b0, 64'h43, 2'd0, 1'b0, 64'h0, rd, er);
      chk("lb_signed", 0, rd, 64'hFFFFFFFFFFFFFFAB);
      do_req(0, 1'b0, 64'h43, 2'd0, 1'b1, 64'h0, rd, er);
      chk("lbu", 0, rd, 64'h00000000000000AB);
      do_req(0, 1'b0, 64'h46, 2'd1, 1'b0, 64'h0, rd, er);
      chk("lh", 0, rd, 64'h0000000000001122);
      do_req(0, 1'b1, 64'h42, 2'd2, 1'b0, 64'hDEADBEEFDEADBEEF, rd, er);
      chk("sw_misaligned_err", 0, 64'(er), 64'd1);
      do_req(0, 1'b0, 64'h40, 2'd3, 1'b0, 64'h0, rd, er);
      chk("after_misaligned", 0, rd, 64'h11223344AB667788);
      do_req(0, 1'b0, 64'h41, 2'd1, 1'b0, 64'h0, rd, er);
      chk("lh_misaligned_err", 0, 64'(er), 64'd1);
      chk("lh_misaligned_data", 0, rd, 64'd0);
      do_req(0, 1'b1, 64'h80, 2'd3, 1'b0, 64'hCAFEF00D12345678, rd, er);
      do_req(0, 1'b0, 64'h00, 2'd3, 1'b0, 64'h0, rd, er);
      chk("wrap", 0, rd, 64'hCAFEF00D12345678);

      // Back-to-back loads with valid held high on the LATENCY=3 instance
      s = acc_cyc[1].size();
      @(posedge clk); #1;
      t_we = 1'b0; t_addr = 64'h08; t_size = 2'd3; t_uns = 1'b0;
      t_valid[1] = 1'b1;
      repeat (14) @(posedge clk);
      #1 t_valid[1] = 1'b0;
      repeat (6) @(posedge clk);
      chk("b2b_count", 1, 64'(acc_cyc[1].size() - s >= 3), 64'd1);
      for (int i = s + 1; i < acc_cyc[1].size(); i++)
         chk("b2b_gap", 1, 64'(acc_cyc[1][i] - acc_cyc[1][i-1]), 64'd4);

      // Reset while waiting: the response is dropped
      @(posedge clk); #1;
      t_we = 1'b0; t_addr = 64'h10; t_size = 2'd3;
      t_valid[1] = 1'b1;
      @(posedge clk); #1;
      t_valid[1] = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 1, 64'(w_ready[1]), 64'd1);
      for (int i = 0; i < 5; i++) begin
         chk("no_rsp_after_reset", 1, 64'(w_rsp[1]), 64'd0);
         @(negedge clk);
      end

      // Randomized traffic on both instances
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 120; k++) begin
            sz = 2'($urandom_range(3));
            a  = {$urandom, $urandom};
            if ($urandom_range(3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            do_req(d, 1'($urandom_range(1)), a, sz, 1'($urandom_range(1)),
                   {$urandom, $urandom}, rd, er);
            repeat ($urandom_range(2)) @(posedge clk);
         end
      end

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/data_memory.md
# data_memory

Parametrised, byte-addressed data memory for the processor's MEM stage, replacing the fixed 64-bit, doubleword-only memory. Adds RISC-V sub-word access: byte, half, word and double stores via byte lanes, and sign- or zero-extended loads. Adds misalignment detection, a configurable read latency, and a valid/ready request handshake with a response pulse. It sits between the execute/MEM pipeline registers and the writeback mux; the core stalls on `req_ready`/`rsp_valid`.

## Interface
- `XLEN`, 64: data width in bits, 32 or 64.
- `DEPTH`, 32768: number of XLEN-wide words, power of two.
- `LATENCY`, 1: cycles from request acceptance to `rsp_valid`, 1..4.
- `clk`  in  1  clock, all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  64  byte address.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_wdata`  in  XLEN  store data, taken from its low bytes.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  XLEN  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned or unsupported size; valid with `rsp_valid`.

## Operation
- Word index is `req_addr[OFF_W +: IDX_W]`, where OFF_W = log2(XLEN/8) and IDX_W = log2(DEPTH).
  - Byte offset is `req_addr[OFF_W-1:0]`.
  - Upper address bits are ignored, so addresses wrap modulo DEPTH*XLEN/8.
- Error rule: the offset must be a multiple of the access size (2^req_size bytes).
  - `req_size`=3 with XLEN=32 is also an error.
  - On error: no memory write, `rsp_rdata`=0, `rsp_err`=1.
- Store: only the addressed byte lanes are written, from the low 2^size bytes of `req_wdata`. The other bytes of the word are unchanged.
- Load: the addressed bytes are shifted to bit 0, then extended per `req_unsigned`. Size = XLEN returns the word as is.
- FSM states: IDLE, WAIT.
  - IDLE: `req_ready`=1. When `req_valid`=1, accept, load the counter with LATENCY-1 and go to WAIT.
  - WAIT: `req_ready`=0. Decrement the counter each cycle. When the counter is 0, assert `rsp_valid` for that cycle and return to IDLE.
- One request is outstanding at a time.
- Memory contents are not reset and are not initialised.

## Timing
- Reset values: state=IDLE, `req_ready`=1 (in the cycle after reset), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- During the reset cycle itself, `req_ready`=0.
- Acceptance edge: the store write and the load word read (registered) both happen on the edge where `req_valid && req_ready`.
  - A load accepted after a store always sees that store's data.
- `rsp_valid` is high exactly LATENCY cycles after the acceptance edge.
- `req_ready` is low from the acceptance edge until `rsp_valid` is high.
- `req_ready` rises in the cycle after `rsp_valid`.
- Throughput: one request per LATENCY+1 cycles.
- Request inputs are sampled only at the acceptance edge; changes while in WAIT are ignored.
- `rsp_rdata` and `rsp_err` hold their values until the next response. The consumer uses them only with `rsp_valid`.
- Reset mid-operation: the pending response is dropped and no `rsp_valid` is issued. A store already accepted remains written.

## Structure
- Shared package `mem_pkg`:
  - size enum: `MEM_B`, `MEM_H`, `MEM_W`, `MEM_D`;
  - state enum: `MS_IDLE`, `MS_WAIT`;
  - function `mem_misaligned(size, offset, xlen)`.
- One sub-module, `mem_load_align`: combinational extract and extend of (word, offset, size, unsigned), returning XLEN bits.
- The byte-lane write mask is built inline in `data_memory`.

## Test plan
- Store and load a double, LATENCY=1:
  - store 0x1122334455667788 to 0x40, then load size 3 from 0x40;
  - required: `rsp_rdata`=0x1122334455667788, `rsp_valid` one cycle after acceptance, `rsp_err`=0.
- Byte lanes:
  - after the above, store byte 0xAB to 0x43, then load a double from 0x40;
  - required: 0x11223344AB667788.
- Extension: load byte from 0x43 returns 0xFFFFFFFFFFFFFFAB signed and 0x00000000000000AB unsigned.
  - Load half from 0x46 (0x1122) returns 0x0000000000001122.
- Misalignment:
  - store word to 0x42: `rsp_err`=1, and a following double load from 0x40 is unchanged;
  - load half from 0x41: `rsp_err`=1, `rsp_rdata`=0.
- Latency and handshake with LATENCY=3:
  - hold `req_valid` high for back-to-back loads;
  - required: acceptances 4 cycles apart, `rsp_valid` exactly 3 cycles after each acceptance, `req_ready`=0 in between.
- Reset and wrap:
  - assert `rst` during WAIT: no `rsp_valid` follows, and `req_ready`=1 the cycle after reset deasserts;
  - with DEPTH=16, XLEN=64, store to 0x80 then load from 0x00: the stored value is returned.
